// File: rtl/cpu_clken_ctrl.sv
// 65C02 bus-slot clock-enable scheduler with run/halt/step control.
// Define CPU_CLKEN_BKPT_EN to build in the address breakpoint.
module cpu_clken_ctrl #(
  parameter int DIVIDE     = 16,
  parameter int VIA_DIVIDE = 4,
  parameter int PHI2_LOW   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        step_instr,
  input  logic        cpu_sync,
  input  logic [15:0] cpu_ab,
  input  logic [15:0] bkpt_addr,
  input  logic        bkpt_en,
  output logic        cpu_clken,
  output logic        cpu_clken1,
  output logic        via_clken,
  output logic        phi2,
  output logic        halted,
  output logic        bkpt_hit
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] PHI_END = CW'(PHI2_LOW - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_STEP
  } state_t;

  state_t         r_state;
  state_t         w_nstate;
  logic [CW-1:0]  r_cnt;
  logic           r_clken;
  logic           r_clken1;
  logic           r_via;
  logic           r_phi2;
  logic           r_first;
  logic           r_instr;

  logic           w_dp;
  logic           w_grant;
  logic           w_nfirst;
  logic           w_ninstr;
  logic           w_nbkpt;
  logic           w_nskip;
  logic           w_bkpt;
  logic           w_skip;
  logic           w_match;
  logic           w_via_hit;
  logic [31:0]    w_cnt32;

  assign w_dp      = (r_cnt == CNT_MAX);
  assign w_cnt32   = 32'(r_cnt);
  assign w_via_hit = (w_cnt32 % 32'(VIA_DIVIDE))
                     == 32'(VIA_DIVIDE - 1);

  always_comb begin
    w_nstate = r_state;
    w_grant  = 1'b0;
    w_nfirst = r_first;
    w_ninstr = r_instr;
    w_nbkpt  = w_bkpt;
    w_nskip  = w_skip;
    case (r_state)
      S_RUN: begin
        if (w_dp) begin
          w_nskip = 1'b0;
          if (!run_req) begin
            w_nstate = S_HALT;
          end else if (w_match && !w_skip) begin
            w_nbkpt  = 1'b1;
            w_nstate = S_HALT;
          end else begin
            w_grant = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (step_req) begin
          w_nstate = S_STEP;
          w_nfirst = 1'b1;
          w_ninstr = step_instr;
          w_nbkpt  = 1'b0;
        end else if (run_req && !w_bkpt) begin
          w_nstate = S_RUN;
          w_nskip  = 1'b1;
        end else if (!run_req) begin
          w_nbkpt = 1'b0;
        end
      end
      S_STEP: begin
        if (w_dp) begin
          // an opcode fetch after the first slot starts the next instruction
          if (r_instr && cpu_sync && !r_first) begin
            w_nstate = S_HALT;
          end else begin
            w_grant  = 1'b1;
            w_nfirst = 1'b0;
            if (!r_instr) begin
              w_nstate = S_HALT;
            end
          end
        end
      end
      default: begin
        w_nstate = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_cnt    <= '0;
      r_clken  <= 1'b0;
      r_clken1 <= 1'b0;
      r_via    <= 1'b0;
      r_phi2   <= 1'b0;
      r_first  <= 1'b0;
      r_instr  <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_dp ? '0 : r_cnt + CW'(1);
      r_clken  <= w_grant;
      r_clken1 <= r_clken;
      r_via    <= w_via_hit;
      r_first  <= w_nfirst;
      r_instr  <= w_ninstr;
      if (w_grant) begin
        r_phi2 <= 1'b1;
      end else if (r_cnt == PHI_END) begin
        r_phi2 <= 1'b0;
      end
    end
  end

`ifdef CPU_CLKEN_BKPT_EN
  logic r_bkpt;
  logic r_skip;

  assign w_match = bkpt_en && cpu_sync
                   && (cpu_ab == bkpt_addr);
  assign w_bkpt  = r_bkpt;
  assign w_skip  = r_skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bkpt <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      r_bkpt <= w_nbkpt;
      r_skip <= w_nskip;
    end
  end
`else
  logic w_unused;

  assign w_match  = 1'b0;
  assign w_bkpt   = 1'b0;
  assign w_skip   = 1'b0;
  assign w_unused = ^{w_nbkpt, w_nskip, bkpt_en,
                      bkpt_addr, cpu_ab};
`endif

  assign cpu_clken  = r_clken;
  assign cpu_clken1 = r_clken1;
  assign via_clken  = r_via;
  assign phi2       = r_phi2;
  assign halted     = (r_state == S_HALT);
  assign bkpt_hit   = w_bkpt;

endmodule

// File: tb/tb_cpu_clken_ctrl.sv
// Directed bench for cpu_clken_ctrl at DIVIDE=16.
// Breakpoint checks follow CPU_CLKEN_BKPT_EN.
module tb_cpu_clken_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_req = 1'b1;
  logic        step_req = 1'b0;
  logic        step_instr = 1'b0;
  logic        cpu_sync = 1'b0;
  logic [15:0] cpu_ab = 16'h0000;
  logic [15:0] bkpt_addr = 16'h0000;
  logic        bkpt_en = 1'b0;
  logic        cpu_clken;
  logic        cpu_clken1;
  logic        via_clken;
  logic        phi2;
  logic        halted;
  logic        bkpt_hit;

  always #5 clk = ~clk;

  cpu_clken_ctrl #(
    .DIVIDE(16),
    .VIA_DIVIDE(4),
    .PHI2_LOW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run_req(run_req),
    .step_req(step_req),
    .step_instr(step_instr),
    .cpu_sync(cpu_sync),
    .cpu_ab(cpu_ab),
    .bkpt_addr(bkpt_addr),
    .bkpt_en(bkpt_en),
    .cpu_clken(cpu_clken),
    .cpu_clken1(cpu_clken1),
    .via_clken(via_clken),
    .phi2(phi2),
    .halted(halted),
    .bkpt_hit(bkpt_hit)
  );

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_ce = 0;
  int n_via = 0;
  int n_phi = 0;
  int n_ce1_bad = 0;
  int last_ce = 0;
  int ce_gap = 0;
  bit prev_ce = 1'b0;
  bit rst_d = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && !rst_d && (cpu_clken1 !== prev_ce))
      n_ce1_bad = n_ce1_bad + 1;
    prev_ce = (cpu_clken === 1'b1);
    rst_d = reset;
    if (via_clken === 1'b1) n_via = n_via + 1;
    if (phi2 === 1'b1) n_phi = n_phi + 1;
    if (cpu_clken === 1'b1) begin
      n_ce = n_ce + 1;
      ce_gap = cyc - last_ce;
      last_ce = cyc;
    end
  end

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk = n_chk + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ce(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (cpu_clken) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_ce", int'(ok), 1);
  endtask

  int b_ce;
  int b_via;
  int b_phi;
  int k;

  task automatic snap();
    b_ce  = n_ce;
    b_via = n_via;
    b_phi = n_phi;
  endtask

  initial begin
    ticks(3);
    chk("rst_ce", int'(cpu_clken), 0);
    chk("rst_ce1", int'(cpu_clken1), 0);
    chk("rst_via", int'(via_clken), 0);
    chk("rst_phi2", int'(phi2), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_bkpt", int'(bkpt_hit), 0);

    reset = 1'b0;
    ticks(15);
    chk("first_ce_early", int'(cpu_clken), 0);
    tick();
    chk("first_ce", int'(cpu_clken), 1);
    chk("first_phi2", int'(phi2), 1);
    chk("run_halted", int'(halted), 0);
    tick();
    chk("first_ce1", int'(cpu_clken1), 1);
    chk("ce_width", int'(cpu_clken), 0);
    ticks(6);
    chk("phi2_hi7", int'(phi2), 1);
    tick();
    chk("phi2_fall", int'(phi2), 0);

    snap();
    ticks(64);
    chk("run_ce_cnt", n_ce - b_ce, 4);
    chk("run_via_cnt", n_via - b_via, 16);
    chk("run_phi_cnt", n_phi - b_phi, 32);
    chk("run_ce_gap", ce_gap, 16);

    wait_ce(20);
    ticks(5);
    run_req = 1'b0;
    ticks(10);
    chk("drop_pre_halt", int'(halted), 0);
    tick();
    chk("drop_halted", int'(halted), 1);
    chk("drop_no_ce", int'(cpu_clken), 0);
    snap();
    ticks(48);
    chk("halt_ce_cnt", n_ce - b_ce, 0);
    chk("halt_phi_cnt", n_phi - b_phi, 0);
    chk("halt_via_cnt", n_via - b_via, 12);
    chk("halt_still", int'(halted), 1);

    step_instr = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_left_halt", int'(halted), 0);
    snap();
    ticks(47);
    chk("step_cyc_cnt", n_ce - b_ce, 1);
    chk("step_cyc_halt", int'(halted), 1);

    ticks(15);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ticks(15);
    chk("step_lat_early", int'(cpu_clken), 0);
    tick();
    chk("step_lat_ce", int'(cpu_clken), 1);
    chk("step_lat_halt", int'(halted), 1);

    step_instr = 1'b1;
    k = 0;
    cpu_sync = 1'b1;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 79; i++) begin
      tick();
      if (cpu_clken) begin
        k = k + 1;
        cpu_sync = ((k % 3) == 0);
      end
    end
    chk("step_ins_cnt", k, 3);
    chk("step_ins_halt", int'(halted), 1);

    cpu_sync = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ticks(19);
    chk("mid_step", int'(halted), 0);
    reset = 1'b1;
    run_req = 1'b1;
    tick();
    chk("rst2_ce", int'(cpu_clken), 0);
    chk("rst2_ce1", int'(cpu_clken1), 0);
    chk("rst2_via", int'(via_clken), 0);
    chk("rst2_phi2", int'(phi2), 0);
    chk("rst2_halted", int'(halted), 0);
    chk("rst2_bkpt", int'(bkpt_hit), 0);
    tick();
    reset = 1'b0;
    ticks(15);
    chk("rst2_ce_early", int'(cpu_clken), 0);
    tick();
    chk("rst2_ce_resume", int'(cpu_clken), 1);
    chk("rst2_run", int'(halted), 0);

    bkpt_addr = 16'hE123;
    cpu_ab = 16'hE123;
    bkpt_en = 1'b1;
    cpu_sync = 1'b1;
`ifdef CPU_CLKEN_BKPT_EN
    ticks(16);
    chk("bk_halted", int'(halted), 1);
    chk("bk_hit", int'(bkpt_hit), 1);
    chk("bk_no_ce", int'(cpu_clken), 0);
    ticks(16);
    chk("bk_hold", int'(halted), 1);
    run_req = 1'b0;
    tick();
    chk("bk_clear", int'(bkpt_hit), 0);
    run_req = 1'b1;
    tick();
    chk("bk_resume", int'(halted), 0);
    snap();
    ticks(16);
    chk("bk_skip_ce", n_ce - b_ce, 1);
    ticks(16);
    chk("bk_rehalt", int'(halted), 1);
    chk("bk_rehit", int'(bkpt_hit), 1);
    chk("bk_one_ce", n_ce - b_ce, 1);
    step_instr = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("bk_step_clr", int'(bkpt_hit), 0);
`else
    snap();
    ticks(32);
    chk("nobk_ce_cnt", n_ce - b_ce, 2);
    chk("nobk_hit", int'(bkpt_hit), 0);
    chk("nobk_run", int'(halted), 0);
`endif

    chk("ce1_follow", n_ce1_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
